// File: rtl/periph_bus_decoder.sv
// Peripheral-window address decoder with per-slot request fan-out, response
// mux, slave timeout and sticky bus-error reporting.

module periph_bus_decoder_lane (
  input  logic        i_sel,
  input  logic        i_ready,
  input  logic [31:0] i_rdata,
  output logic        o_ready,
  output logic [31:0] o_rdata
);
  // Only the slot currently holding slv_valid may complete or drive data.
  assign o_ready = i_sel & i_ready;
  assign o_rdata = i_sel ? i_rdata : '0;
endmodule

module periph_bus_decoder #(
  parameter int          NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = 32'h0200_0000,
  parameter int          SLOT_BITS      = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                       sys_clk,
  input  logic                       rst_n,
  input  logic                       periph_mem_valid,
  output logic                       periph_mem_ready,
  input  logic [31:0]                periph_mem_addr,
  input  logic [31:0]                periph_mem_wdata,
  input  logic [3:0]                 periph_mem_wstrb,
  output logic [31:0]                periph_mem_rdata,
  output logic [NUM_SLAVES-1:0]      slv_valid,
  input  logic [NUM_SLAVES-1:0]      slv_ready,
  output logic [SLOT_BITS-1:0]       slv_addr,
  output logic [31:0]                slv_wdata,
  output logic [3:0]                 slv_wstrb,
  input  logic [32*NUM_SLAVES-1:0]   slv_rdata,
  input  logic                       err_clr,
  output logic                       bus_err,
  output logic [7:0]                 err_count,
  output logic [31:0]                err_addr
);

  localparam int              DW      = 32 - SLOT_BITS;
  localparam int              IW      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [DW-1:0]   NS_D    = DW'(NUM_SLAVES);
  localparam logic [15:0]     TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t                         r_state, w_state_nxt;
  req_t                           r_req;
  logic [NUM_SLAVES-1:0]          r_slv_valid;
  logic [15:0]                    r_tmo_cnt;
  logic [31:0]                    r_rdata;
  logic                           r_bus_err;
  logic [7:0]                     r_err_count;
  logic [31:0]                    r_err_addr;

  logic [DW-1:0]                  w_diff;
  logic                           w_hit;
  logic [IW-1:0]                  w_idx;
  logic                           w_tmo;
  logic                           w_slv_rdy;
  logic [31:0]                    w_rdata_sel;
  logic                           w_err_ev;
  logic [31:0]                    w_err_addr;
  logic [NUM_SLAVES-1:0]          w_lane_rdy;
  logic [NUM_SLAVES-1:0][31:0]    w_lane_rdata;

  // Wrapping subtraction: addresses below the window become huge and miss.
  assign w_diff = periph_mem_addr[31:SLOT_BITS] - BASE_ADDR[31:SLOT_BITS];
  assign w_hit  = (w_diff < NS_D);
  assign w_idx  = w_diff[IW-1:0];
  assign w_tmo  = (r_tmo_cnt == TO_LAST);

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_lane
    periph_bus_decoder_lane u_lane (
      .i_sel   (r_slv_valid[g]),
      .i_ready (slv_ready[g]),
      .i_rdata (slv_rdata[32*g +: 32]),
      .o_ready (w_lane_rdy[g]),
      .o_rdata (w_lane_rdata[g])
    );
  end

  always_comb begin
    w_rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) w_rdata_sel = w_rdata_sel | w_lane_rdata[i];
  end
  assign w_slv_rdy = |w_lane_rdy;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err_ev    = 1'b0;
    w_err_addr  = r_req.addr;
    case (r_state)
      S_IDLE: begin
        w_err_addr = periph_mem_addr;
        if (periph_mem_valid) begin
          w_state_nxt = w_hit ? S_ACCESS : S_RESP;
          w_err_ev    = !w_hit;
        end
      end
      S_ACCESS: begin
        // Ready on the final cycle still wins over the timeout.
        if (w_slv_rdy) begin
          w_state_nxt = S_RESP;
        end else if (w_tmo) begin
          w_state_nxt = S_RESP;
          w_err_ev    = 1'b1;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req       <= '0;
      r_slv_valid <= '0;
      r_tmo_cnt   <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (periph_mem_valid) begin
            if (w_hit) begin
              r_req       <= '{addr: periph_mem_addr, wdata: periph_mem_wdata,
                               wstrb: periph_mem_wstrb};
              r_slv_valid <= NUM_SLAVES'(1) << w_idx;
              r_tmo_cnt   <= '0;
            end else begin
              r_rdata     <= ERR_RDATA;
            end
          end
        end
        S_ACCESS: begin
          r_tmo_cnt <= r_tmo_cnt + 16'd1;
          if (w_slv_rdy) begin
            r_rdata     <= w_rdata_sel;
            r_slv_valid <= '0;
          end else if (w_tmo) begin
            r_rdata     <= ERR_RDATA;
            r_slv_valid <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Error set takes priority over a coincident clear.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err   <= 1'b0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else if (w_err_ev) begin
      r_bus_err  <= 1'b1;
      r_err_addr <= w_err_addr;
      if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
    end else if (err_clr) begin
      r_bus_err <= 1'b0;
    end
  end

  assign periph_mem_ready = (r_state == S_RESP) && periph_mem_valid;
  assign periph_mem_rdata = r_rdata;
  assign slv_valid        = r_slv_valid;
  assign slv_addr         = r_req.addr[SLOT_BITS-1:0];
  assign slv_wdata        = r_req.wdata;
  assign slv_wstrb        = r_req.wstrb;
  assign bus_err          = r_bus_err;
  assign err_count        = r_err_count;
  assign err_addr         = r_err_addr;

endmodule

// File: tb/tb_periph_bus_decoder.sv
// Directed plus randomized bench for periph_bus_decoder; the bench plays CPU
// and slaves and checks against an address-range/latency reference model.

module tb_periph_bus_decoder;
  localparam int          NS   = 4;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] ERR  = 32'hDEAD_BEEF;
  localparam int          SPAN = 65536;

  logic              sys_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              periph_mem_valid = 1'b0;
  logic              periph_mem_ready;
  logic [31:0]       periph_mem_addr  = '0;
  logic [31:0]       periph_mem_wdata = '0;
  logic [3:0]        periph_mem_wstrb = '0;
  logic [31:0]       periph_mem_rdata;
  logic [NS-1:0]     slv_valid;
  logic [NS-1:0]     slv_ready = '0;
  logic [15:0]       slv_addr;
  logic [31:0]       slv_wdata;
  logic [3:0]        slv_wstrb;
  logic [32*NS-1:0]  slv_rdata = '0;
  logic              err_clr = 1'b0;
  logic              bus_err;
  logic [7:0]        err_count;
  logic [31:0]       err_addr;

  int n_checks = 0;
  int n_err    = 0;

  logic        m_bus_err   = 1'b0;
  int          m_err_count = 0;
  logic [31:0] m_err_addr  = '0;

  periph_bus_decoder #(
    .NUM_SLAVES(NS), .BASE_ADDR(BASE), .SLOT_BITS(16),
    .TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR)
  ) dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .periph_mem_valid(periph_mem_valid), .periph_mem_ready(periph_mem_ready),
    .periph_mem_addr(periph_mem_addr), .periph_mem_wdata(periph_mem_wdata),
    .periph_mem_wstrb(periph_mem_wstrb), .periph_mem_rdata(periph_mem_rdata),
    .slv_valid(slv_valid), .slv_ready(slv_ready), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata),
    .err_clr(err_clr), .bus_err(bus_err), .err_count(err_count), .err_addr(err_addr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_err(input logic [31:0] a);
    m_bus_err  = 1'b1;
    m_err_addr = a;
    if (m_err_count < 255) m_err_count++;
  endtask

  task automatic chk_err_regs(input string tag);
    chk({tag, ".bus_err"},   bus_err,   m_bus_err);
    chk({tag, ".err_count"}, err_count, m_err_count);
    chk({tag, ".err_addr"},  err_addr,  m_err_addr);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"},     periph_mem_ready, 0);
    chk({tag, ".rdata"},     periph_mem_rdata, 0);
    chk({tag, ".slv_valid"}, slv_valid, 0);
    chk({tag, ".slv_addr"},  slv_addr,  0);
    chk({tag, ".slv_wdata"}, slv_wdata, 0);
    chk({tag, ".slv_wstrb"}, slv_wstrb, 0);
    chk_err_regs(tag);
  endtask

  // One CPU transaction; dly = ready withheld for this many slv_valid cycles.
  task automatic txn(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input int dly, input logic [31:0] srd,
                     input bit wrong);
    bit            hit, done, unstable;
    int            slot, lat, vcnt, exp_lat, exp_v;
    logic [31:0]   rd, exp_rd;
    logic [NS-1:0] v0;
    logic [15:0]   a0;
    logic [31:0]   w0;
    logic [3:0]    s0;
    hit  = (addr >= BASE) && ((addr - BASE) < NS * SPAN);
    slot = hit ? int'((addr - BASE) / SPAN) : 0;
    done = 0; unstable = 0; lat = 0; vcnt = 0; rd = '0;
    v0 = '0; a0 = '0; w0 = '0; s0 = '0;
    @(negedge sys_clk);
    periph_mem_valid = 1'b1;
    periph_mem_addr  = addr;
    periph_mem_wdata = wdata;
    periph_mem_wstrb = wstrb;
    slv_rdata = {$urandom, $urandom, $urandom, $urandom};
    slv_rdata[32*slot +: 32] = srd;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge sys_clk);
      if (periph_mem_ready === 1'b1) begin
        lat = c; rd = periph_mem_rdata; done = 1;
      end
      if (slv_valid != 0) begin
        vcnt++;
        if (vcnt == 1) begin
          v0 = slv_valid; a0 = slv_addr; w0 = slv_wdata; s0 = slv_wstrb;
        end else if (slv_valid !== v0 || slv_addr !== a0 || slv_wdata !== w0 || slv_wstrb !== s0) begin
          unstable = 1;
        end
      end
      slv_ready = '0;
      if (slv_valid != 0 && wrong) slv_ready[(slot + 1) % NS] = 1'b1;
      if (slv_valid != 0 && vcnt - 1 == dly) slv_ready[slot] = 1'b1;
    end
    chk({tag, ".completed"}, done, 1);
    // Request still held in the cycle after RESP: no response, no re-issue.
    @(negedge sys_clk);
    chk({tag, ".hold_ready"}, periph_mem_ready, 0);
    chk({tag, ".hold_valid"}, slv_valid, 0);
    periph_mem_valid = 1'b0;
    slv_ready = '0;
    if (!hit) begin
      exp_lat = 1; exp_v = 0; exp_rd = ERR; model_err(addr);
    end else if (dly < TO) begin
      exp_lat = dly + 2; exp_v = dly + 1; exp_rd = srd;
    end else begin
      exp_lat = TO + 1; exp_v = TO; exp_rd = ERR; model_err(addr);
    end
    chk({tag, ".latency"}, lat, exp_lat);
    chk({tag, ".valid_cycles"}, vcnt, exp_v);
    chk({tag, ".rdata"}, rd, exp_rd);
    if (hit) begin
      chk({tag, ".slv_valid"}, v0, NS'(1) << slot);
      chk({tag, ".slv_addr"},  a0, addr[15:0]);
      chk({tag, ".slv_wdata"}, w0, wdata);
      chk({tag, ".slv_wstrb"}, s0, wstrb);
      chk({tag, ".stable"},    unstable, 0);
    end
    chk_err_regs(tag);
  endtask

  initial begin
    logic [31:0] ra;
    int          rs;
    #2;
    chk_reset_outputs("reset0");
    @(negedge sys_clk);
    rst_n = 1'b1;

    txn("slot2_read",  32'h0202_0010, 32'h0,          4'b0000, 1,  32'h1234_5678, 0);
    txn("slot0_write", 32'h0200_0004, 32'hAABB_CCDD,  4'b0011, 0,  32'h0,         0);
    txn("unmapped",    32'h0204_0000, 32'h0,          4'b0000, 0,  32'h0,         0);
    txn("timeout",     32'h0201_0040, 32'h0,          4'b0000, 99, 32'h5555_AAAA, 0);
    txn("ready_last",  32'h0201_0044, 32'h0,          4'b0000, TO - 1, 32'h0BAD_F00D, 0);
    txn("wrong_slot",  32'h0203_FFFC, 32'h1111_2222,  4'b1111, 3,  32'h7777_8888, 1);
    txn("below_win",   32'h01FF_FFFC, 32'h0,          4'b0000, 0,  32'h0,         0);

    // CPU withdraws before the response cycle: ready must stay low.
    @(negedge sys_clk);
    periph_mem_valid = 1'b1;
    periph_mem_addr  = 32'h0300_0000;
    @(negedge sys_clk);
    periph_mem_valid = 1'b0;
    #1;
    chk("withdraw.ready", periph_mem_ready, 0);
    model_err(32'h0300_0000);
    @(negedge sys_clk);
    chk_err_regs("withdraw");

    for (int i = 0; i < 300; i++)
      txn("sat_miss", 32'h0204_0000 + 32'(i * 4), 32'h0, 4'b0000, 0, 32'h0, 0);
    chk("sat.err_count", err_count, 255);

    @(negedge sys_clk);
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    m_bus_err = 1'b0;
    chk_err_regs("clr_only");

    // Clear coincident with a new miss: set wins.
    periph_mem_valid = 1'b1;
    periph_mem_addr  = 32'h0205_0000;
    err_clr = 1'b1;
    @(negedge sys_clk);
    err_clr = 1'b0;
    chk("clr_miss.ready", periph_mem_ready, 1);
    periph_mem_valid = 1'b0;
    model_err(32'h0205_0000);
    chk_err_regs("clr_miss");
    @(negedge sys_clk);

    // Reset in the middle of an access.
    periph_mem_valid = 1'b1;
    periph_mem_addr  = 32'h0203_0100;
    periph_mem_wdata = 32'hCAFE_0001;
    periph_mem_wstrb = 4'b1000;
    @(negedge sys_clk);
    @(negedge sys_clk);
    chk("midrst.pre_valid", slv_valid, 4'b1000);
    rst_n = 1'b0;
    #1;
    m_bus_err = 1'b0; m_err_count = 0; m_err_addr = '0;
    chk_reset_outputs("midrst");
    periph_mem_valid = 1'b0;
    @(negedge sys_clk);
    rst_n = 1'b1;
    txn("post_rst", 32'h0203_0100, 32'hCAFE_0002, 4'b1000, 2, 32'h600D_0001, 0);

    for (int i = 0; i < 80; i++) begin
      rs = int'($urandom_range(0, 6));
      if (rs == 6) ra = BASE - 32'(SPAN) + ($urandom & 32'h0000_FFFC);
      else         ra = BASE + 32'(rs * SPAN) + ($urandom & 32'h0000_FFFC);
      txn("rand", ra, $urandom, 4'($urandom), int'($urandom_range(0, 10)), $urandom,
          ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
